// File: rtl/fork_3_sync.sv
// Three-way 4-phase handshake fork: one decode-side request is steered to the
// branch/jump, store or ALU/load/NOP path by opcode, with per-path dispatch counters.
module fork_3_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_in,
  input  logic [DW-1:0] instr_in,
  output logic          ack_out,
  output logic          req_out_1,
  output logic          req_out_2,
  output logic          req_out_3,
  input  logic          ack_in_1,
  input  logic          ack_in_2,
  input  logic          ack_in_3,
  output logic [DW-1:0] instr_out,
  output logic          illegal,
  output logic [15:0]   cnt_1,
  output logic [15:0]   cnt_2,
  output logic [15:0]   cnt_3
);

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    RELEASE,
    DRAIN
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] ack1_sync;
  logic [SYNC_STAGES-1:0] ack2_sync;
  logic [SYNC_STAGES-1:0] ack3_sync;

  logic       req_s;
  logic       ack_sel;
  logic [1:0] sel;
  logic [1:0] path_d;
  logic [1:0] dec_path;
  logic [2:0] req_d;
  logic       ack_d;
  logic       capture;
  logic       complete;

  // Path code 0 marks an unrecognised opcode; 1..3 name the output path.
  function automatic logic [1:0] decode_path(input logic [6:0] op);
    case (op)
      7'b1100011, 7'b1101111:                         decode_path = 2'd1;
      7'b0100011:                                     decode_path = 2'd2;
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0000000: decode_path = 2'd3;
      default:                                        decode_path = 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync  <= '0;
      ack1_sync <= '0;
      ack2_sync <= '0;
      ack3_sync <= '0;
    end else begin
      req_sync  <= {req_sync[SYNC_STAGES-2:0], req_in};
      ack1_sync <= {ack1_sync[SYNC_STAGES-2:0], ack_in_1};
      ack2_sync <= {ack2_sync[SYNC_STAGES-2:0], ack_in_2};
      ack3_sync <= {ack3_sync[SYNC_STAGES-2:0], ack_in_3};
    end
  end

  assign req_s    = req_sync[SYNC_STAGES-1];
  assign dec_path = decode_path(instr_in[6:0]);

  // Only the acknowledge of the captured path can move the FSM.
  always_comb begin
    ack_sel = 1'b0;
    case (sel)
      2'd1:    ack_sel = ack1_sync[SYNC_STAGES-1];
      2'd2:    ack_sel = ack2_sync[SYNC_STAGES-1];
      2'd3:    ack_sel = ack3_sync[SYNC_STAGES-1];
      default: ack_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state;
    path_d   = sel;
    capture  = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (req_s) begin
          capture = 1'b1;
          path_d  = dec_path;
          state_d = (dec_path == 2'd0) ? DRAIN : DISPATCH;
        end
      end
      DISPATCH: begin
        if (ack_sel) state_d = RELEASE;
      end
      RELEASE: begin
        if (!ack_sel) begin
          complete = 1'b1;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (!req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs come from the next state so they rise on the deciding edge.
    req_d = 3'b000;
    if (state_d == DISPATCH) begin
      case (path_d)
        2'd1:    req_d = 3'b001;
        2'd2:    req_d = 3'b010;
        2'd3:    req_d = 3'b100;
        default: req_d = 3'b000;
      endcase
    end
    ack_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      req_out_1 <= 1'b0;
      req_out_2 <= 1'b0;
      req_out_3 <= 1'b0;
      ack_out   <= 1'b0;
      instr_out <= '0;
      illegal   <= 1'b0;
      cnt_1     <= 16'd0;
      cnt_2     <= 16'd0;
      cnt_3     <= 16'd0;
    end else begin
      state                           <= state_d;
      sel                             <= path_d;
      {req_out_3, req_out_2, req_out_1} <= req_d;
      ack_out                         <= ack_d;
      if (capture) instr_out <= instr_in;
      if (capture && dec_path == 2'd0) illegal <= 1'b1;
      if (complete) begin
        case (sel)
          2'd1:    cnt_1 <= cnt_1 + 16'd1;
          2'd2:    cnt_2 <= cnt_2 + 16'd1;
          2'd3:    cnt_3 <= cnt_3 + 16'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fork_3_sync.sv
// Directed and randomized handshake bench for fork_3_sync, checked against an
// opcode-table / per-path-count reference model.
module tb_fork_3_sync;

  localparam int SYNC = 2;
  localparam int DW   = 32;

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          req_in   = 1'b0;
  logic [DW-1:0] instr_in = '0;
  logic          ack_in_1 = 1'b0;
  logic          ack_in_2 = 1'b0;
  logic          ack_in_3 = 1'b0;
  logic          ack_out;
  logic          req_out_1, req_out_2, req_out_3;
  logic [DW-1:0] instr_out;
  logic          illegal;
  logic [15:0]   cnt_1, cnt_2, cnt_3;

  int checks      = 0;
  int errors      = 0;
  int onehot_viol = 0;
  logic [2:0] seen_req = 3'b000;

  logic [15:0]   exp_cnt [1:3];
  logic          exp_illegal;
  logic [DW-1:0] exp_instr;

  fork_3_sync #(.SYNC_STAGES(SYNC), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .instr_in(instr_in), .ack_out(ack_out),
    .req_out_1(req_out_1), .req_out_2(req_out_2), .req_out_3(req_out_3),
    .ack_in_1(ack_in_1), .ack_in_2(ack_in_2), .ack_in_3(ack_in_3),
    .instr_out(instr_out), .illegal(illegal),
    .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3)
  );

  always #5 clk = ~clk;

  // Record every path request seen and any cycle with more than one raised.
  always @(negedge clk) begin
    seen_req = seen_req | {req_out_3, req_out_2, req_out_1};
    if ((32'(req_out_1) + 32'(req_out_2) + 32'(req_out_3)) > 1) onehot_viol++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelPath(input logic [6:0] op);
    if (op == 7'b1100011 || op == 7'b1101111) return 1;
    if (op == 7'b0100011) return 2;
    if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 || op == 7'b0000000) return 3;
    return 0;
  endfunction

  function automatic logic sigVal(input int which);
    case (which)
      1:       return req_out_1;
      2:       return req_out_2;
      3:       return req_out_3;
      default: return ack_out;
    endcase
  endfunction

  task automatic waitSignal(input int which, input logic val, input int limit,
                            output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (sigVal(which) === val) ok = 1'b1;
    end
  endtask

  task automatic setAck(input int p, input logic v);
    case (p)
      1:       ack_in_1 = v;
      2:       ack_in_2 = v;
      default: ack_in_3 = v;
    endcase
  endtask

  task automatic modelReset();
    exp_cnt[1]  = 16'd0;
    exp_cnt[2]  = 16'd0;
    exp_cnt[3]  = 16'd0;
    exp_illegal = 1'b0;
    exp_instr   = '0;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_cnt1"}, 64'(cnt_1), 64'(exp_cnt[1]));
    checkOutput({tag, "_cnt2"}, 64'(cnt_2), 64'(exp_cnt[2]));
    checkOutput({tag, "_cnt3"}, 64'(cnt_3), 64'(exp_cnt[3]));
    checkOutput({tag, "_illegal"}, 64'(illegal), 64'(exp_illegal));
    checkOutput({tag, "_instr_hold"}, 64'(instr_out), 64'(exp_instr));
  endtask

  task automatic cleanReset();
    @(negedge clk);
    rst = 1'b1;
    req_in = 1'b0;
    ack_in_1 = 1'b0;
    ack_in_2 = 1'b0;
    ack_in_3 = 1'b0;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One full 4-phase transaction from the decode side, with the selected path
  // answering after ack_delay cycles; optional glitches on ack_in_1.
  task automatic applyStimulus(input logic [DW-1:0] instr, input int ack_delay,
                               input bit noise_ack1, input string tag);
    int p, cyc;
    bit ok;
    logic [2:0] exp_mask;
    p = modelPath(instr[6:0]);
    @(negedge clk);
    seen_req = 3'b000;
    instr_in = instr;
    req_in = 1'b1;
    exp_instr = instr;
    if (p != 0) begin
      waitSignal(p, 1'b1, 20, cyc, ok);
      checkOutput({tag, "_req_rise"}, 64'(ok), 64'd1);
      checkOutput({tag, "_req_latency"}, 64'(cyc), 64'(SYNC + 1));
      checkOutput({tag, "_instr_during_req"}, 64'(instr_out), 64'(instr));
      checkOutput({tag, "_ack_out_low"}, 64'(ack_out), 64'd0);
      if (noise_ack1 && p != 1) begin
        repeat (2) begin
          ack_in_1 = 1'b1;
          repeat (SYNC + 2) @(negedge clk);
          ack_in_1 = 1'b0;
          repeat (SYNC + 2) @(negedge clk);
        end
        checkOutput({tag, "_req_held_noise"}, 64'(sigVal(p)), 64'd1);
      end
      repeat (ack_delay) @(negedge clk);
      setAck(p, 1'b1);
      waitSignal(p, 1'b0, 20, cyc, ok);
      checkOutput({tag, "_req_fall"}, 64'(ok), 64'd1);
      repeat (ack_delay) @(negedge clk);
      setAck(p, 1'b0);
      waitSignal(0, 1'b1, 20, cyc, ok);
      checkOutput({tag, "_ack_out_rise"}, 64'(ok), 64'd1);
      checkOutput({tag, "_ack_latency"}, 64'(cyc), 64'(SYNC + 1));
      exp_cnt[p] = exp_cnt[p] + 16'd1;
    end else begin
      waitSignal(0, 1'b1, 20, cyc, ok);
      checkOutput({tag, "_ack_out_rise"}, 64'(ok), 64'd1);
      exp_illegal = 1'b1;
    end
    repeat (ack_delay) @(negedge clk);
    req_in = 1'b0;
    waitSignal(0, 1'b0, 20, cyc, ok);
    checkOutput({tag, "_ack_out_fall"}, 64'(ok), 64'd1);
    exp_mask = (p == 0) ? 3'b000 : 3'(1 << (p - 1));
    checkOutput({tag, "_paths_raised"}, 64'(seen_req), 64'(exp_mask));
    checkModel(tag);
  endtask

  logic [6:0] legal_ops [7];
  logic [31:0] rnd;
  logic [6:0]  op;
  int cyc_m;
  bit ok_m;

  initial begin
    legal_ops = '{7'b1100011, 7'b1101111, 7'b0100011, 7'b0110011,
                  7'b0010011, 7'b0000011, 7'b0000000};
    modelReset();

    // Asynchronous reset takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_req1", 64'(req_out_1), 64'd0);
    checkOutput("rst_req2", 64'(req_out_2), 64'd0);
    checkOutput("rst_req3", 64'(req_out_3), 64'd0);
    checkOutput("rst_ack_out", 64'(ack_out), 64'd0);
    checkModel("rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] jump dispatch on path 1");
    applyStimulus(32'h00C0_006F, 0, 1'b0, "jal");
    checkOutput("jal_cnt1_one", 64'(cnt_1), 64'd1);

    cleanReset();
    $display("[TB] back-to-back store, alu, branch");
    applyStimulus(32'h00A1_2023, 0, 1'b0, "b2b_store");
    applyStimulus(32'h0031_0133, 1, 1'b0, "b2b_alu");
    applyStimulus(32'h0020_8063, 2, 1'b0, "b2b_branch");
    checkOutput("b2b_cnt1_one", 64'(cnt_1), 64'd1);
    checkOutput("b2b_cnt2_one", 64'(cnt_2), 64'd1);
    checkOutput("b2b_cnt3_one", 64'(cnt_3), 64'd1);

    cleanReset();
    $display("[TB] illegal opcode");
    applyStimulus(32'hDEAD_BEFF, 0, 1'b0, "illegal_op");
    checkOutput("illegal_set", 64'(illegal), 64'd1);
    applyStimulus(32'h0000_0013, 0, 1'b0, "after_illegal");
    checkOutput("illegal_sticky", 64'(illegal), 64'd1);

    cleanReset();
    $display("[TB] ack_in_1 glitches during a path-3 transaction");
    applyStimulus(32'h1234_5033, 0, 1'b1, "noise");
    checkOutput("noise_cnt1_zero", 64'(cnt_1), 64'd0);

    cleanReset();
    $display("[TB] reset while path 2 is requesting");
    @(negedge clk);
    instr_in = 32'h0051_2023;
    req_in = 1'b1;
    waitSignal(2, 1'b1, 20, cyc_m, ok_m);
    checkOutput("midrst_req2_seen", 64'(ok_m), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_req2_clear", 64'(req_out_2), 64'd0);
    checkOutput("midrst_ack_out_clear", 64'(ack_out), 64'd0);
    checkOutput("midrst_cnt2_zero", 64'(cnt_2), 64'd0);
    modelReset();
    req_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("midrst_idle_ack", 64'(ack_out), 64'd0);
    applyStimulus(32'h0051_2023, 1, 1'b0, "midrst_next");

    cleanReset();
    $display("[TB] cnt_3 wrap");
    // Stands in for 65535 prior ALU dispatches.
    force dut.cnt_3 = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_3;
    exp_cnt[3] = 16'hFFFF;
    @(negedge clk);
    checkOutput("wrap_preload", 64'(cnt_3), 64'hFFFF);
    applyStimulus(32'h0000_0003, 0, 1'b0, "wrap");
    checkOutput("wrap_zero", 64'(cnt_3), 64'd0);

    cleanReset();
    $display("[TB] randomized transactions");
    for (int i = 0; i < 40; i++) begin
      rnd = $urandom();
      if ($urandom_range(0, 5) == 0) op = rnd[6:0];
      else op = legal_ops[$urandom_range(0, 6)];
      applyStimulus({rnd[31:7], op}, int'($urandom_range(0, 3)), 1'b0, "rand");
    end

    checkOutput("onehot_req", 64'(onehot_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fork_3_sync.md
FORK_3_SYNC -- requirements
Module: fork_3_sync

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on each incoming handshake signal (legal range 2..3).
REQ-002 The block SHALL have parameter DW, default 32, giving the width of the instruction payload.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge clocked.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_in, input, 1 bit: 4-phase request from the decode stage; asynchronous to clk.
REQ-006 The block SHALL have port instr_in, input, DW bits: instruction; bits [6:0] are the opcode; stable while req_in=1.
REQ-007 The block SHALL have port ack_out, output, 1 bit: 4-phase acknowledge to the decode stage.
REQ-008 The block SHALL have ports req_out_1, req_out_2, req_out_3, output, 1 bit each: 4-phase requests to the branch/jump, store and ALU/load/NOP paths respectively.
REQ-009 The block SHALL have ports ack_in_1, ack_in_2, ack_in_3, input, 1 bit each: 4-phase acknowledges from those paths; asynchronous to clk.
REQ-010 The block SHALL have port instr_out, output, DW bits: the registered instruction, shared by all three paths.
REQ-011 The block SHALL have port illegal, output, 1 bit: sticky flag set by an unrecognised opcode.
REQ-012 The block SHALL have ports cnt_1, cnt_2, cnt_3, output, 16 bits each: completed-dispatch counters per path.

Function
REQ-013 req_in and each ack_in_k SHALL pass through a SYNC_STAGES-flop synchronizer; the FSM SHALL use only synchronized copies.
REQ-014 Opcode decode SHALL map to paths as follows:
- 1100011 or 1101111 -> path 1
- 0100011 -> path 2
- 0110011, 0010011, 0000011 or 0000000 -> path 3
- any other value -> illegal
REQ-015 The FSM SHALL have states IDLE, DISPATCH, RELEASE, DRAIN; at most one of req_out_1..3 SHALL be high in any cycle.
REQ-016 In IDLE with synchronized req_in=1, the block SHALL on the next edge:
- capture instr_in into instr_out;
- capture the decoded path into a 2-bit select register;
- go to DISPATCH for a legal opcode, or to DRAIN for an illegal one with illegal set to 1.
REQ-017 In DISPATCH, req_out_sel SHALL be registered high; on synchronized ack_in_sel=1 the FSM SHALL go to RELEASE and drop req_out_sel on that edge.
REQ-018 In RELEASE, on synchronized ack_in_sel=0, cnt_sel SHALL increment by 1 (wrapping 0xFFFF -> 0x0000) and the FSM SHALL go to DRAIN.
REQ-019 In DRAIN, ack_out SHALL be registered high; on synchronized req_in=0, ack_out SHALL drop and the FSM SHALL return to IDLE.
REQ-020 instr_out SHALL hold its value from capture until the next capture.
REQ-021 ack_in_k transitions on a non-selected path SHALL be ignored.
REQ-022 Minimum latency SHALL be:
- req_in rise to req_out_sel high: SYNC_STAGES+1 cycles;
- ack_in_sel fall to ack_out high: SYNC_STAGES+1 cycles.
REQ-023 A req_in that rises again while the FSM is not in IDLE SHALL NOT start a new capture until the FSM returns to IDLE.
REQ-024 illegal SHALL clear only on reset; illegal opcodes SHALL NOT change any counter.

Reset
REQ-025 While rst=1, the following SHALL hold immediately and independently of clk:
- req_out_1..3=0, ack_out=0;
- instr_out=0, illegal=0, cnt_1..3=0;
- synchronizers cleared, FSM=IDLE.
REQ-026 Assertion of rst mid-handshake SHALL abort the transaction without a counter update; after release, the FSM SHALL leave IDLE only on a synchronized req_in=1.

Verification
REQ-027 The bench SHALL cover: instr opcode 1101111, req_in=1, path 1 acks promptly -> req_out_1 high SYNC_STAGES+1 cycles later, req_out_2 and req_out_3 stay 0, cnt_1=1, ack_out completes the 4-phase handshake.
REQ-028 The bench SHALL cover: back-to-back opcodes 0100011, 0110011, 1100011 -> one dispatch each on paths 2, 3, 1 in order; final cnt_1=cnt_2=cnt_3=1; instr_out matches each instruction during its request.
REQ-029 The bench SHALL cover: opcode 1111111 -> no req_out_k rises, illegal=1, ack_out handshake completes, all counters 0; illegal stays 1 after a following legal transaction.
REQ-030 The bench SHALL cover: cnt_3 preloaded by 65535 ALU dispatches, then one more -> cnt_3=0x0000.
REQ-031 The bench SHALL cover: rst pulsed while req_out_2=1 -> req_out_2=0 and ack_out=0 immediately, cnt_2 unchanged at 0, next transaction dispatches normally.
REQ-032 The bench SHALL cover: ack_in_1 toggled during a path-3 transaction -> no effect on the FSM or on cnt_1.
